// File: rtl/spi_note_rx.sv
// SPI mode-0 slave that decodes 2-byte note on/off frames into a FWFT event FIFO.
// Optional MISO status readback is enabled by defining SPI_STATUS_READBACK_EN.
module spi_note_rx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int VOICE_W     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_sclk,
    input  logic               i_mosi,
    input  logic               i_cs_n,
    output logic               o_miso,
    input  logic               i_ready,
    output logic               o_SPI_flag,
    output logic               o_SPI_note_status,
    output logic [VOICE_W-1:0] o_SPI_voice_index,
    output logic               o_overflow,
    output logic               o_frame_err,
    input  logic               i_clear_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = VOICE_W + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, mosi_s, cs_s;
    logic                   sclk_rise, cs_rise, cs_fall;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    // After reset the chain still holds idle values; only arm once the real pin
    // level has propagated and shows cs_n high, so a frame cut by reset is ignored.
    logic [2:0] settle;
    logic       armed;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            if (settle != 3'(SYNC_STAGES))
                settle <= settle + 3'd1;
            else if (cs_s)
                armed <= 1'b1;
        end
    end

    state_t      state;
    logic [4:0]  bit_cnt;
    logic [15:0] shreg;
    logic        dec_pulse, short_pulse;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            dec_pulse   <= 1'b0;
            short_pulse <= 1'b0;
        end else begin
            dec_pulse   <= 1'b0;
            short_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall && armed) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state       <= IDLE;
                        short_pulse <= (bit_cnt != 5'd0);
                        bit_cnt     <= '0;
                        shreg       <= '0;
                    end else if (sclk_rise) begin
                        shreg   <= {shreg[14:0], mosi_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd15) begin
                            state     <= DONE;
                            dec_pulse <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (cs_rise) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic          op_on, op_off, wr_en, bad_op;
    logic [EW-1:0] wdata;

    assign op_on  = (shreg[15:8] == 8'h90);
    assign op_off = (shreg[15:8] == 8'h80);
    assign wr_en  = dec_pulse & (op_on | op_off);
    assign bad_op = dec_pulse & ~(op_on | op_off);
    assign wdata  = {op_on, shreg[VOICE_W-1:0]};

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wptr, rptr, count;
    logic          empty, full, pop, push;

    assign count = wptr - rptr;
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign pop   = ~empty & i_ready;
    // A pop in the same cycle frees the slot, so a write into a full FIFO succeeds.
    assign push  = wr_en & (~full | pop);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    assign o_SPI_flag = ~empty;
    assign {o_SPI_note_status, o_SPI_voice_index} = mem[rptr[AW-1:0]];

    logic ovf_set, err_set;
    assign ovf_set = wr_en & full & ~pop;
    assign err_set = bad_op | short_pulse;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_overflow  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_overflow  <= ovf_set | (o_overflow & ~i_clear_err);
            o_frame_err <= err_set | (o_frame_err & ~i_clear_err);
        end
    end

`ifdef SPI_STATUS_READBACK_EN
    logic [7:0] tx;
    logic       sclk_fall;
    logic [3:0] cnt4;

    assign sclk_fall = ~sclk_s & sclk_d;
    assign cnt4      = 4'(count);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            tx <= '0;
        else if (state == IDLE && cs_fall && armed)
            tx <= {o_overflow, o_frame_err, 2'b00, cnt4};
        else if (state != IDLE && sclk_fall)
            tx <= {tx[6:0], 1'b0};
    end

    assign o_miso = ~cs_s & tx[7];
`else
    assign o_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_note_rx.sv
// Bench for spi_note_rx: directed test-plan frames plus random frames checked
// every cycle against a queue-based event model.
module tb_spi_note_rx;

    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int HALF  = 8;
    // Pin edge -> synchroniser -> edge detect -> registered decode -> FIFO/flag write.
    localparam int LAT   = SYNC + 2;

    logic       i_clk = 0, i_reset_n = 0, i_sclk = 0, i_mosi = 0, i_cs_n = 1;
    logic       i_ready = 0, i_clear_err = 0;
    logic       o_miso, o_SPI_flag, o_SPI_note_status, o_overflow, o_frame_err;
    logic [7:0] o_SPI_voice_index;

    always #5 i_clk = ~i_clk;

    spi_note_rx #(.FIFO_DEPTH(DEPTH), .VOICE_W(8), .SYNC_STAGES(SYNC)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_sclk(i_sclk), .i_mosi(i_mosi),
        .i_cs_n(i_cs_n), .o_miso(o_miso), .i_ready(i_ready), .o_SPI_flag(o_SPI_flag),
        .o_SPI_note_status(o_SPI_note_status), .o_SPI_voice_index(o_SPI_voice_index),
        .o_overflow(o_overflow), .o_frame_err(o_frame_err), .i_clear_err(i_clear_err)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: event queue, sticky flags, and frame outcomes due at a given cycle.
    logic [8:0]  mq[$];
    int          due_q[$];
    logic [16:0] ev_q[$];
    bit          m_ovf = 0, m_err = 0, mpop, msov, mser;
    logic [16:0] mev;
    int          cyc = 0;

    task automatic sched(input bit short_kind, input logic [7:0] b0, input logic [7:0] b1);
        due_q.push_back(cyc + LAT);
        ev_q.push_back({short_kind, b0, b1});
    endtask

    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mq.delete(); due_q.delete(); ev_q.delete();
            m_ovf = 0; m_err = 0;
        end else begin
            cyc++;
            mpop = (mq.size() > 0) && i_ready;
            msov = 0; mser = 0;
            if (mpop) void'(mq.pop_front());
            while (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                mev = ev_q.pop_front();
                if (mev[16]) mser = 1;
                else if (mev[15:8] == 8'h90 || mev[15:8] == 8'h80) begin
                    if (mq.size() == DEPTH) msov = 1;
                    else mq.push_back({mev[15:8] == 8'h90, mev[7:0]});
                end else mser = 1;
            end
            m_ovf = msov | (m_ovf & !i_clear_err);
            m_err = mser | (m_err & !i_clear_err);
        end
    end

    bit         cmp_en = 0;
    int         flag_cycles = 0;
    logic [7:0] last_idx = 0;
    logic       last_st = 0;

    always @(negedge i_clk) begin
        if (cmp_en && i_reset_n) begin
            chk("flag", o_SPI_flag, mq.size() > 0);
            if (mq.size() > 0) begin
                chk("status", o_SPI_note_status, mq[0][8]);
                chk("index", o_SPI_voice_index, mq[0][7:0]);
            end
            chk("overflow", o_overflow, m_ovf);
            chk("frame_err", o_frame_err, m_err);
`ifndef SPI_STATUS_READBACK_EN
            chk("miso", o_miso, 0);
`endif
            if (o_SPI_flag) begin
                flag_cycles++;
                last_idx = o_SPI_voice_index;
                last_st  = o_SPI_note_status;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // rst_at > 0 pulses reset after that many bits; the rest of that frame is untracked.
    task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input int nbits,
                         input int rst_at, output logic [7:0] rb);
        logic [15:0] w;
        bit trk;
        w = {b0, b1}; trk = 1; rb = '0;
        tick(1); i_cs_n = 0; tick(4);
        for (int i = 0; i < nbits; i++) begin
            i_mosi = w[15-i];
            tick(HALF);
            if (i < 8) rb[7-i] = o_miso;
            i_sclk = 1;
            if (i == 15 && trk) sched(0, b0, b1);
            tick(HALF);
            i_sclk = 0;
            if (i + 1 == rst_at) begin
                tick(1); i_reset_n = 0; tick(1); i_reset_n = 1; trk = 0;
            end
        end
        tick(4);
        i_cs_n = 1;
        if (trk && nbits > 0 && nbits < 16) sched(1, 8'h00, 8'h00);
        i_mosi = 0;
        tick(4);
    endtask

    task automatic pop_one();
        i_ready = 1; tick(1); i_ready = 0;
    endtask

    task automatic clear_err();
        i_clear_err = 1; tick(1); i_clear_err = 0;
    endtask

    bit rnd = 0;
    initial begin
        forever begin
            @(posedge i_clk); #1;
            if (rnd) begin
                i_ready     = 1'($urandom_range(0, 1));
                i_clear_err = ($urandom_range(0, 19) == 0);
            end
        end
    end

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        #5_000_000;
        failures++;
        $display("FAIL timeout actual=running expected=finished");
        summary();
        $finish;
    end

    logic [7:0] rb;
    logic [7:0] op, idx;
    int         r, nb;

    initial begin
        tick(3); i_reset_n = 1; tick(6);
        cmp_en = 1;
        chk("rst_flag", o_SPI_flag, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_err", o_frame_err, 0);
        chk("rst_miso", o_miso, 0);
        chk("rst_idx", o_SPI_voice_index, 0);

        // Single note-on with consumer ready: one-cycle pulse.
        i_ready = 1; flag_cycles = 0;
        frame(8'h90, 8'h05, 16, -1, rb); tick(4);
        chk("t1_pulse", flag_cycles, 1);
        chk("t1_idx", last_idx, 8'h05);
        chk("t1_st", last_st, 1);
        chk("t1_err", o_frame_err, 0);

        // Two events held, then popped over two ready cycles.
        i_ready = 0;
        frame(8'h80, 8'h03, 16, -1, rb);
        frame(8'h90, 8'h07, 16, -1, rb); tick(2);
        chk("t2_flag", o_SPI_flag, 1);
        chk("t2_st", o_SPI_note_status, 0);
        chk("t2_idx", o_SPI_voice_index, 8'h03);
        i_ready = 1; tick(1);
        chk("t2_flag2", o_SPI_flag, 1);
        chk("t2_st2", o_SPI_note_status, 1);
        chk("t2_idx2", o_SPI_voice_index, 8'h07);
        tick(1); i_ready = 0;
        chk("t2_empty", o_SPI_flag, 0);

        // Five frames into a 4-deep FIFO: fifth dropped, overflow sticky.
        for (int k = 0; k < 5; k++) frame(8'h90, 8'(8'h10 + k), 16, -1, rb);
        tick(2);
        chk("t3_ovf", o_overflow, 1);
        for (int k = 0; k < 2; k++) begin
            chk("t3_idx", o_SPI_voice_index, 8'h10 + k);
            pop_one();
        end
`ifdef SPI_STATUS_READBACK_EN
        frame(8'h80, 8'h20, 16, -1, rb);
        chk("rb_status", rb, 8'h82);
`endif
        for (int k = 2; k < 4; k++) begin
            chk("t3_idx", o_SPI_voice_index, 8'h10 + k);
            pop_one();
        end
        i_ready = 1; tick(3); i_ready = 0;
        chk("t3_empty", o_SPI_flag, 0);
        clear_err();
        chk("t3_ovf_clr", o_overflow, 0);

        // Short frame (9 bits) then a good frame.
        i_ready = 1; flag_cycles = 0;
        frame(8'h5A, 8'h00, 9, -1, rb); tick(1);
        chk("t4_err", o_frame_err, 1);
        chk("t4_noev", flag_cycles, 0);
        frame(8'h90, 8'h01, 16, -1, rb); tick(2);
        chk("t4_pulse", flag_cycles, 1);
        chk("t4_idx", last_idx, 8'h01);
        clear_err();

        // Bad opcode: no event, error until cleared.
        flag_cycles = 0;
        frame(8'hA0, 8'h33, 16, -1, rb); tick(1);
        chk("t5_err", o_frame_err, 1);
        chk("t5_noev", flag_cycles, 0);
        clear_err();
        chk("t5_clr", o_frame_err, 0);

        // Reset mid-frame with an event pending and the error flag set.
        i_ready = 0;
        frame(8'h90, 8'h09, 16, -1, rb);
        frame(8'h11, 8'h22, 16, -1, rb);
        tick(1);
        chk("t6_pre_flag", o_SPI_flag, 1);
        chk("t6_pre_err", o_frame_err, 1);
        frame(8'h90, 8'h55, 16, 6, rb);
        chk("t6_flag", o_SPI_flag, 0);
        chk("t6_err", o_frame_err, 0);
        chk("t6_ovf", o_overflow, 0);
        frame(8'h80, 8'h02, 16, -1, rb); tick(1);
        chk("t6_nflag", o_SPI_flag, 1);
        chk("t6_nst", o_SPI_note_status, 0);
        chk("t6_nidx", o_SPI_voice_index, 8'h02);
        pop_one();

        // Random frames with random back-pressure and error clears.
        rnd = 1;
        for (int n = 0; n < 80; n++) begin
            r   = $urandom_range(0, 99);
            idx = 8'($urandom_range(0, 255));
            nb  = 16;
            if (r < 70) op = (r % 2 == 1) ? 8'h90 : 8'h80;
            else if (r < 85) op = 8'($urandom_range(0, 255));
            else begin
                op = 8'h90;
                nb = $urandom_range(0, 15);
            end
            frame(op, idx, nb, -1, rb);
        end
        rnd = 0;
        tick(1); i_ready = 1; i_clear_err = 0; tick(8);
        chk("final_empty", o_SPI_flag, 0);
        summary();
        $finish;
    end

endmodule
